// File: rtl/dcache_sram_2.sv
// rtl/dcache_sram_2.sv - simple dual-port byte-enabled RAM, independent write/read clocks
// Read-first on same-clock collisions; neither reset clears the array.
module dcache_sram_2 #(
   parameter int WR_ADDR_WIDTH = 9,
   parameter int WR_DATA_WIDTH = 32,
   parameter int RD_ADDR_WIDTH = 9,
   parameter int RD_DATA_WIDTH = 32,
   parameter int BE_WIDTH      = 4,
   parameter int BYTE_SIZE     = 8
) (
   input  logic                     wr_clk,
   input  logic                     tb_wr_rst,
   input  logic                     rd_clk,
   input  logic                     rd_rst,
   input  logic                     wr_en,
   input  logic [WR_ADDR_WIDTH-1:0] wr_addr,
   input  logic [WR_DATA_WIDTH-1:0] wr_data,
   input  logic [BE_WIDTH-1:0]      wr_byte_en,
   input  logic [RD_ADDR_WIDTH-1:0] rd_addr,
   output logic [RD_DATA_WIDTH-1:0] rd_data
);

   localparam int DEPTH = 2 ** WR_ADDR_WIDTH;

   logic [WR_DATA_WIDTH-1:0] mem [DEPTH];
   logic [BE_WIDTH-1:0]      lane_we;
   logic [RD_DATA_WIDTH-1:0] rd_data_d;
   logic [RD_DATA_WIDTH-1:0] rd_data_q;

   // Write reset only gates the strobe, so the array stays a plain unreset RAM.
   always_comb begin
      lane_we = '0;
      if (wr_en && !tb_wr_rst) begin
         lane_we = wr_byte_en;
      end
   end

   always_ff @(posedge wr_clk) begin
      for (int i = 0; i < BE_WIDTH; i++) begin
         if (lane_we[i]) begin
            mem[wr_addr][i*BYTE_SIZE +: BYTE_SIZE] <= wr_data[i*BYTE_SIZE +: BYTE_SIZE];
         end
      end
   end

   always_comb begin
      rd_data_d = mem[rd_addr];
   end

   always_ff @(posedge rd_clk or posedge rd_rst) begin
      if (rd_rst) begin
         rd_data_q <= '0;
      end else begin
         rd_data_q <= rd_data_d;
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: tb/tb_dcache_sram_2.sv
// tb/tb_dcache_sram_2.sv - directed bench for dcache_sram_2
// Both ports share one clock so the read-first collision case is observable.
module tb_dcache_sram_2;

   logic        clk = 1'b0;
   logic        tb_wr_rst;
   logic        rd_rst;
   logic        wr_en;
   logic [8:0]  wr_addr;
   logic [31:0] wr_data;
   logic [3:0]  wr_byte_en;
   logic [8:0]  rd_addr;
   logic [31:0] rd_data;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   dcache_sram_2 dut (
      .wr_clk     (clk),
      .tb_wr_rst  (tb_wr_rst),
      .rd_clk     (clk),
      .rd_rst     (rd_rst),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .wr_byte_en (wr_byte_en),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data)
   );

   task automatic check(input string tag, input logic [31:0] exp);
      checks++;
      assert (rd_data === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, rd_data, exp);
      end
   endtask

   task automatic read_word(input string tag, input logic [8:0] a, input logic [31:0] exp);
      rd_addr = a;
      @(negedge clk);
      check(tag, exp);
   endtask

   initial begin
      tb_wr_rst  = 1'b1;
      rd_rst     = 1'b1;
      wr_en      = 1'b0;
      wr_addr    = '0;
      wr_data    = '0;
      wr_byte_en = '0;
      rd_addr    = '0;

      // 200 ns of reset on both ports, read data held at zero throughout
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         rd_addr = 9'(k * 7);
         check("reset_hold", 32'h0000_0000);
      end
      tb_wr_rst = 1'b0;
      rd_rst    = 1'b0;

      // Fill addresses 1..511 then 0 with a decrementing pattern
      for (int i = 0; i < 512; i++) begin
         wr_en      = 1'b1;
         wr_addr    = 9'((i + 1) % 512);
         wr_data    = 32'hFFFF_FFFF - 32'(i);
         wr_byte_en = 4'hF;
         @(negedge clk);
      end
      wr_en = 1'b0;

      for (int i = 0; i < 512; i++) begin
         read_word("fill_read", 9'((i + 1) % 512), 32'hFFFF_FFFF - 32'(i));
      end

      // Byte-lane merge
      wr_en = 1'b1; wr_addr = 9'd5; wr_data = 32'hAABB_CCDD; wr_byte_en = 4'hF;
      @(negedge clk);
      wr_data = 32'h1122_3344; wr_byte_en = 4'h5;
      @(negedge clk);
      wr_en = 1'b0;
      read_word("byte_en_merge", 9'd5, 32'hAA22_CC44);

      // Disabled write must not touch memory
      wr_en = 1'b0; wr_addr = 9'd5; wr_data = 32'h0; wr_byte_en = 4'hF;
      @(negedge clk);
      read_word("wr_en_low", 9'd5, 32'hAA22_CC44);

      // Zero byte enables with wr_en high must not touch memory
      wr_en = 1'b1; wr_addr = 9'd5; wr_data = 32'h0; wr_byte_en = 4'h0;
      @(negedge clk);
      wr_en = 1'b0;
      read_word("be_zero", 9'd5, 32'hAA22_CC44);

      // Write reset blocks writes and keeps contents
      tb_wr_rst = 1'b1;
      wr_en = 1'b1; wr_addr = 9'd5; wr_data = 32'h0; wr_byte_en = 4'hF;
      @(negedge clk);
      wr_en = 1'b0;
      tb_wr_rst = 1'b0;
      read_word("wr_rst_blocks", 9'd5, 32'hAA22_CC44);

      // Read reset mid-stream: immediate clear, held, then reload
      read_word("pre_rd_rst", 9'd10, 32'hFFFF_FFF6);
      #2 rd_rst = 1'b1;
      #1 check("rd_rst_async", 32'h0000_0000);
      @(negedge clk);
      check("rd_rst_held", 32'h0000_0000);
      rd_addr = 9'd3;
      @(negedge clk);
      check("rd_rst_held_addr_change", 32'h0000_0000);
      rd_rst = 1'b0;
      @(negedge clk);
      check("rd_rst_release", 32'hFFFF_FFFD);
      read_word("post_rd_rst_addr5", 9'd5, 32'hAA22_CC44);
      read_word("post_rd_rst_addr0", 9'd0, 32'hFFFF_FE00);

      // Same-clock collision at address 7 returns old data first
      wr_en = 1'b1; wr_addr = 9'd7; wr_data = 32'h1234_5678; wr_byte_en = 4'hF;
      rd_addr = 9'd7;
      @(negedge clk);
      wr_en = 1'b0;
      check("collision_old", 32'hFFFF_FFF9);
      @(negedge clk);
      check("collision_new", 32'h1234_5678);

      // Address wrap: neighbours unaffected
      read_word("addr_511", 9'd511, 32'hFFFF_FE01);
      read_word("addr_6", 9'd6, 32'hFFFF_FFFA);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/dcache_sram_2.md
DCACHE_SRAM_2 -- requirements
Module: dcache_sram_2

Interface
REQ-001 SHALL expose parameter WR_ADDR_WIDTH, default 9, write address width (512 words).
REQ-002 SHALL expose parameter WR_DATA_WIDTH, default 32, write data width.
REQ-003 SHALL expose parameter RD_ADDR_WIDTH, default 9, read address width; equal to WR_ADDR_WIDTH.
REQ-004 SHALL expose parameter RD_DATA_WIDTH, default 32, read data width; equal to WR_DATA_WIDTH.
REQ-005 SHALL expose parameter BE_WIDTH, default 4, number of byte-enable lanes (WR_DATA_WIDTH/BYTE_SIZE).
REQ-006 SHALL expose parameter BYTE_SIZE, default 8, bits per byte lane.
REQ-007 wr_clk  input  1  write-port clock; reset tb_wr_rst, asynchronous, active-high; clock wr_clk.
REQ-008 tb_wr_rst  input  1  write-side reset, asynchronous, active-high.
REQ-009 rd_clk  input  1  read-port clock, independent of wr_clk.
REQ-010 rd_rst  input  1  read-side reset, asynchronous, active-high.
REQ-011 wr_en  input  1  write strobe, sampled on rising wr_clk.
REQ-012 wr_addr  input  WR_ADDR_WIDTH  write word address.
REQ-013 wr_data  input  WR_DATA_WIDTH  write data.
REQ-014 wr_byte_en  input  BE_WIDTH  byte-lane write enables; bit i gates wr_data[8i+7:8i].
REQ-015 rd_addr  input  RD_ADDR_WIDTH  read word address, always enabled.
REQ-016 rd_data  output  RD_DATA_WIDTH  registered read data.

Function
REQ-017 SHALL implement a simple dual-port RAM of 2**WR_ADDR_WIDTH words x WR_DATA_WIDTH bits, one write port and one read port.
REQ-018 On rising wr_clk with wr_en=1 and tb_wr_rst=0, SHALL write lane i of mem[wr_addr] with wr_data lane i for each wr_byte_en[i]=1; lanes with wr_byte_en[i]=0 SHALL keep their contents.
REQ-019 wr_en=0 SHALL leave memory unchanged regardless of wr_addr, wr_data, wr_byte_en.
REQ-020 On every rising rd_clk with rd_rst=0, SHALL load rd_data with mem[rd_addr]; read latency exactly 1 rd_clk cycle, no output register stage, no read enable, no output clock enable.
REQ-021 rd_data SHALL hold its value between rd_clk edges.
REQ-022 Same-address read and write on coincident edges (same clock source) SHALL return old data (read-first); with asynchronous clocks the result for that collision is undefined.
REQ-023 Addresses SHALL be taken modulo 2**WR_ADDR_WIDTH; no out-of-range condition exists.
REQ-024 Memory contents after power-up SHALL be unspecified (no initialisation file); reads of unwritten locations SHALL not be checked.
REQ-025 Behaviour SHALL be unaffected by a GTP_GRS global-reset primitive instantiated alongside with GRS_N=1.

Reset
REQ-026 rd_rst=1 SHALL asynchronously force rd_data to 0 and hold it at 0 while asserted; first post-reset rd_clk edge loads mem[rd_addr].
REQ-027 tb_wr_rst=1 SHALL asynchronously block writes while asserted; memory contents SHALL NOT be cleared by either reset.
REQ-028 Resets mid-operation SHALL leave previously written words intact and readable after release.

Verification
REQ-029 Reset both ports 200 ns -> rd_data=0x00000000 throughout reset.
REQ-030 Write addresses 1..511 then 0 (wrap), data 0xFFFFFFFF decrementing per write, wr_byte_en=0xF; read same address order -> rd_data one rd_clk after each address equals 0xFFFFFFFF, 0xFFFFFFFE, ... exactly (512 words, zero mismatches).
REQ-031 Write 0xAABBCCDD to addr 5, then write 0x11223344 with wr_byte_en=0x5 -> read of addr 5 returns 0xAA22CC44.
REQ-032 wr_en=0 with wr_addr=5, wr_data=0 -> addr 5 still reads 0xAA22CC44.
REQ-033 Assert rd_rst during a read stream -> rd_data goes 0 immediately; after release, data at the current rd_addr appears after one rd_clk, memory unchanged.
REQ-034 Same-clock write 0x12345678 and read at addr 7 in the same cycle -> rd_data shows the old value; the next cycle shows 0x12345678.
